// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

    // Width of the wait-state down-counter (supports 0..15 wait states).
    localparam int unsigned DMEM_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    // Byte-lane write enables: one little-endian lane for byte accesses, all four for words.
    function automatic logic [3:0] dmem_lane_en(input logic byte_acc, input logic [1:0] lane);
        logic [3:0] en;
        en = 4'b1111;
        if (byte_acc) begin
            en = 4'b0001 << lane;
        end
        return en;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port word RAM with per-byte write enables and registered read.
// Contents are never reset.
module dmem_array #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              en,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Lane-masked write and read-before-write registered read on enabled cycles.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the memory-stage bus: accepts one load/store,
// inserts WAIT_CYCLES wait states, commits on the edge entering RESP and
// returns a one-cycle MemReady pulse with read data.
// Optional feature macro: DMEM_BYTE_ACCESS_EN (byte loads/stores via ByteAcc).
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReq,
    input  logic        MemWrite,
    input  logic        ByteAcc,
    input  logic [31:0] Adr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        MemReady,
    output logic        MemBusy
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    dmem_state_t           state, state_nx;
    logic [DMEM_CNT_W-1:0] cnt, cnt_nx;
    logic                  accept, commit;
    logic                  busy_q;

    logic                  wr_q;
    logic [AW-1:0]         idx_q;
    logic [31:0]           wdata_q;

    logic                  acc_wr;
    logic [AW-1:0]         acc_idx;
    logic [31:0]           acc_wdata;
    logic [3:0]            ram_we;
    logic [31:0]           ram_wdata;
    logic [31:0]           ram_rdata;
    logic [31:0]           rd_sel;
    logic [3:0]            lane_en;

    // With zero wait states the commit edge is also the accept edge, so the
    // access fields come straight from the bus while IDLE and from the latches otherwise.
    assign acc_wr    = (state == IDLE) ? MemWrite          : wr_q;
    assign acc_idx   = (state == IDLE) ? Adr[AW+1:2]       : idx_q;
    assign acc_wdata = (state == IDLE) ? WriteData         : wdata_q;

`ifdef DMEM_BYTE_ACCESS_EN
    logic       byte_q;
    logic [1:0] lane_q;
    logic       acc_byte;
    logic [1:0] acc_lane;

    assign acc_byte  = (state == IDLE) ? ByteAcc  : byte_q;
    assign acc_lane  = (state == IDLE) ? Adr[1:0] : lane_q;
    assign lane_en   = dmem_lane_en(acc_byte, acc_lane);
    assign ram_wdata = acc_byte ? {4{acc_wdata[7:0]}} : acc_wdata;
    assign rd_sel    = byte_q ? {24'd0, ram_rdata[8*lane_q +: 8]} : ram_rdata;

    // Byte-access fields captured alongside the rest of the request.
    always_ff @(posedge clk) begin
        if (accept) begin
            byte_q <= ByteAcc;
            lane_q <= Adr[1:0];
        end
    end
`else
    logic unused_byte;

    assign unused_byte = ^{ByteAcc, Adr[1:0]};
    assign lane_en     = '1;
    assign ram_wdata   = acc_wdata;
    assign rd_sel      = ram_rdata;
`endif

    logic unused_adr_hi;
    assign unused_adr_hi = ^Adr[31:AW+2];

    // Next-state, wait counter and commit strobe; reset suppresses the commit.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        accept   = 1'b0;
        commit   = 1'b0;
        case (state)
            IDLE: begin
                if (MemReq) begin
                    accept = 1'b1;
                    cnt_nx = DMEM_CNT_W'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        state_nx = RESP;
                        commit   = 1'b1;
                    end else begin
                        state_nx = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_nx = cnt - 1'b1;
                if (cnt == DMEM_CNT_W'(1)) begin
                    state_nx = RESP;
                    commit   = 1'b1;
                end
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        if (reset) begin
            accept = 1'b0;
            commit = 1'b0;
        end
    end

    // State register, wait counter and registered busy flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            busy_q <= (state_nx != IDLE);
        end
    end

    // Request fields held for the duration of the access.
    always_ff @(posedge clk) begin
        if (accept) begin
            wr_q    <= MemWrite;
            idx_q   <= Adr[AW+1:2];
            wdata_q <= WriteData;
        end
    end

    assign ram_we = (commit && acc_wr) ? lane_en : '0;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (AW)
    ) u_array (
        .clk   (clk),
        .en    (commit),
        .we    (ram_we),
        .addr  (acc_idx),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign MemReady = (state == RESP);
    assign MemBusy  = busy_q;
    assign ReadData = (state == RESP && !wr_q) ? rd_sel : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a WAIT_CYCLES=2 instance (index 0)
// and a WAIT_CYCLES=0 instance (index 1) share clock and reset.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 64;
`ifdef DMEM_BYTE_ACCESS_EN
    localparam bit BYTE_EN = 1'b1;
`else
    localparam bit BYTE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req   [2];
    logic        we    [2];
    logic        byt   [2];
    logic [31:0] adr   [2];
    logic [31:0] wd    [2];
    logic [31:0] rdata [2];
    logic        rdy   [2];
    logic        busy  [2];

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] mdl [2][DEPTH];
    int          waits [2];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut0 (
        .clk(clk), .reset(reset), .MemReq(req[0]), .MemWrite(we[0]), .ByteAcc(byt[0]),
        .Adr(adr[0]), .WriteData(wd[0]), .ReadData(rdata[0]), .MemReady(rdy[0]), .MemBusy(busy[0])
    );

    dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut1 (
        .clk(clk), .reset(reset), .MemReq(req[1]), .MemWrite(we[1]), .ByteAcc(byt[1]),
        .Adr(adr[1]), .WriteData(wd[1]), .ReadData(rdata[1]), .MemReady(rdy[1]), .MemBusy(busy[1])
    );

    typedef struct {
        bit          wr;
        bit          b;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference behaviour: word index wraps modulo DEPTH, little-endian byte lanes.
    function automatic void model_access(input int d, input bit wr, input bit b_in,
                                         input logic [31:0] a, input logic [31:0] data,
                                         output logic [31:0] exp);
        int unsigned w    = (a / 4) % DEPTH;
        int unsigned lane = a % 4;
        bit          b    = b_in && BYTE_EN;
        logic [31:0] mask = 32'hFF << (8 * lane);
        if (wr) begin
            exp = 32'd0;
            if (b) mdl[d][w] = (mdl[d][w] & ~mask) | ((data & 32'hFF) << (8 * lane));
            else   mdl[d][w] = data;
        end else begin
            exp = b ? ((mdl[d][w] >> (8 * lane)) & 32'hFF) : mdl[d][w];
        end
    endfunction

    // One bus transaction: hold MemReq until MemReady, drop it the cycle after.
    task automatic access(input int d, input bit wr, input bit b, input logic [31:0] a,
                          input logic [31:0] data, output logic [31:0] rd,
                          output int lat, output int nbusy);
        @(posedge clk); #1;
        req[d] = 1'b1; we[d] = wr; byt[d] = b; adr[d] = a; wd[d] = data;
        lat = -1; nbusy = 0; rd = 32'hxxxxxxxx;
        for (int k = 0; k < 40 && lat < 0; k++) begin
            @(negedge clk);
            if (busy[d]) nbusy++;
            if (rdy[d]) begin
                lat = k;
                rd  = rdata[d];
            end
        end
        @(posedge clk); #1;
        req[d] = 1'b0;
        @(negedge clk);
        check($sformatf("single_pulse[%0d]", d), {31'd0, rdy[d]}, 32'd0);
        check($sformatf("busy_clear[%0d]", d), {31'd0, busy[d]}, 32'd0);
    endtask

    task automatic access_chk(input int d, input string name, input bit wr, input bit b,
                              input logic [31:0] a, input logic [31:0] data,
                              input logic [31:0] exp);
        logic [31:0] rd;
        int          lat, nb;
        access(d, wr, b, a, data, rd, lat, nb);
        check({name, "_data"}, rd, exp);
        check({name, "_lat"}, 32'(lat), 32'(waits[d] + 1));
        check({name, "_busy"}, 32'(nb), 32'(waits[d] + 1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        tbl [10];
        logic [31:0] e;
        int          lat;
        bit          seen;

        waits[0] = 2;
        waits[1] = 0;
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; we[d] = 1'b0; byt[d] = 1'b0; adr[d] = '0; wd[d] = '0;
        end

        tbl[0] = '{1'b1, 1'b0, 32'h10,  32'hDEADBEEF, 32'h0};
        tbl[1] = '{1'b0, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF};
        tbl[2] = '{1'b1, 1'b0, 32'h100, 32'h12345678, 32'h0};
        tbl[3] = '{1'b0, 1'b0, 32'h0,   32'h0,        32'h12345678};
        tbl[4] = '{1'b0, 1'b0, 32'h103, 32'h0,        32'h12345678};
        tbl[5] = '{1'b1, 1'b0, 32'h20,  32'h11223344, 32'h0};
        tbl[6] = '{1'b1, 1'b1, 32'h21,  32'h000000AA, 32'h0};
        tbl[7] = '{1'b0, 1'b0, 32'h20,  32'h0,        BYTE_EN ? 32'h1122AA44 : 32'h000000AA};
        tbl[8] = '{1'b0, 1'b1, 32'h23,  32'h0,        BYTE_EN ? 32'h00000011 : 32'h000000AA};
        tbl[9] = '{1'b1, 1'b0, 32'h30,  32'h11111111, 32'h0};

        // Reset state
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_ready[%0d]", d), {31'd0, rdy[d]}, 32'd0);
            check($sformatf("rst_busy[%0d]", d), {31'd0, busy[d]}, 32'd0);
            check($sformatf("rst_rdata[%0d]", d), rdata[d], 32'd0);
        end

        // Directed table on the two-wait-state instance
        for (int i = 0; i < 10; i++) begin
            access_chk(0, $sformatf("vec%0d", i), tbl[i].wr, tbl[i].b, tbl[i].a, tbl[i].d, tbl[i].exp);
        end

        // MemReq dropped during WAIT: access completes with the latched fields
        @(posedge clk); #1;
        req[0] = 1'b1; we[0] = 1'b1; byt[0] = 1'b0; adr[0] = 32'h38; wd[0] = 32'h0BADC0DE;
        @(posedge clk); #1;
        req[0] = 1'b0; we[0] = 1'b0; adr[0] = 32'h24; wd[0] = 32'hFFFFFFFF;
        lat = -1;
        for (int k = 1; k < 40 && lat < 0; k++) begin
            @(negedge clk);
            if (rdy[0]) lat = k;
        end
        check("drop_lat", 32'(lat), 32'd3);
        access_chk(0, "drop_rd38", 1'b0, 1'b0, 32'h38, 32'h0, 32'h0BADC0DE);
        access_chk(0, "drop_rd20", 1'b0, 1'b0, 32'h20, 32'h0, BYTE_EN ? 32'h1122AA44 : 32'h000000AA);

        // Reset in the first WAIT cycle aborts the store
        @(posedge clk); #1;
        req[0] = 1'b1; we[0] = 1'b1; byt[0] = 1'b0; adr[0] = 32'h30; wd[0] = 32'hCAFEF00D;
        @(posedge clk); #1;
        reset = 1'b1; req[0] = 1'b0;
        @(negedge clk);
        check("abort_ready_wait", {31'd0, rdy[0]}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_ready", {31'd0, rdy[0]}, 32'd0);
        check("abort_busy", {31'd0, busy[0]}, 32'd0);
        check("abort_rdata", rdata[0], 32'd0);
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (rdy[0]) seen = 1'b1;
        end
        check("abort_no_ready", {31'd0, seen}, 32'd0);
        access_chk(0, "abort_rd30", 1'b0, 1'b0, 32'h30, 32'h0, 32'h11111111);

        // Reset in RESP keeps the committed store
        @(posedge clk); #1;
        req[0] = 1'b1; we[0] = 1'b1; byt[0] = 1'b0; adr[0] = 32'h34; wd[0] = 32'h5A5A1234;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (rdy[0]) seen = 1'b1;
        end
        check("resp_rst_seen", {31'd0, seen}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; req[0] = 1'b0;
        @(negedge clk);
        check("resp_rst_busy", {31'd0, busy[0]}, 32'd0);
        check("resp_rst_ready", {31'd0, rdy[0]}, 32'd0);
        access_chk(0, "resp_rst_rd34", 1'b0, 1'b0, 32'h34, 32'h0, 32'h5A5A1234);

        // Randomised traffic against the reference model, both instances
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                logic [31:0] a, data;
                a    = ($urandom & 32'hFFFF_FF00) | (32'(i) * 4) % (4 * DEPTH);
                data = $urandom;
                model_access(d, 1'b1, 1'b0, a, data, e);
                access_chk(d, $sformatf("init%0d_%0d", d, i), 1'b1, 1'b0, a, data, e);
            end
            for (int i = 0; i < 150; i++) begin
                bit          wr, b;
                logic [31:0] a, data;
                wr   = 1'($urandom_range(0, 1));
                b    = 1'($urandom_range(0, 1));
                a    = $urandom;
                data = $urandom;
                model_access(d, wr, b, a, data, e);
                access_chk(d, $sformatf("rand%0d_%0d", d, i), wr, b, a, data, e);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder on the pipelined ARM core's memory-stage bus. It accepts one load or store request at a time from the core (initiator) and inserts a programmable number of wait states. It completes the access against an internal word array and returns a one-cycle `MemReady` pulse with read data. The core stalls its memory stage on `MemReq & ~MemReady`.

## Interface
- `DEPTH_WORDS`, 64: number of 32-bit words; power of two, ≥ 4.
- `WAIT_CYCLES`, 2: wait states between acceptance and response; 0–15.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `MemReq`  in  1  request valid; held with all fields stable until `MemReady`.
- `MemWrite`  in  1  1 = store, 0 = load.
- `ByteAcc`  in  1  1 = byte access (LDRB/STRB), 0 = word.
- `Adr`  in  32  byte address.
- `WriteData`  in  32  store data.
- `ReadData`  out  32  load data; valid only while `MemReady`=1.
- `MemReady`  out  1  one-cycle completion pulse.
- `MemBusy`  out  1  registered; 1 whenever state ≠ IDLE.

## Operation
- FSM states are IDLE, WAIT and RESP.
  - IDLE: when `MemReq`=1 at an edge, latch `MemWrite`, `ByteAcc`, `Adr` and `WriteData`.
    - Load `cnt` with `WAIT_CYCLES`.
    - Next state is WAIT if `WAIT_CYCLES` > 0, else RESP.
  - WAIT: decrement `cnt` each edge. At the edge where `cnt`==1, go to RESP.
  - RESP: `MemReady`=1 for exactly this cycle. `MemReq` is ignored. Next state is always IDLE.
- Commit point is the edge entering RESP. That edge writes the array (store) or registers `ReadData` (load).
- Word index is `Adr[$clog2(DEPTH_WORDS)+1:2]`. Higher address bits are ignored, so addresses alias and wrap modulo `4*DEPTH_WORDS`. For word accesses, `Adr[1:0]` is ignored.
- Byte access is little-endian, lane `Adr[1:0]`:
  - Load returns the byte zero-extended to 32 bits.
  - Store writes `WriteData[7:0]` into that lane only; the other lanes are preserved.
- Stores drive `ReadData` to 0 in RESP.
- Array contents are not reset and are undefined until written.

## Timing
- Reset values: state IDLE, `cnt`=0, `MemReady`=0, `MemBusy`=0, `ReadData`=0. The array is untouched.
- Latency: with `MemReq` first high in cycle n, `MemReady`=1 in cycle n+1+`WAIT_CYCLES`.
- Throughput: one access per `WAIT_CYCLES`+3 cycles. The core drops `MemReq` in the cycle after `MemReady`, so IDLE is re-entered and the next request is accepted no earlier than the cycle after RESP.
- `MemReq` dropping during WAIT does not abort the access; it completes with the latched fields.
- Reset asserted in WAIT aborts the access: a pending store is not committed and no `MemReady` is produced. Reset asserted in RESP still leaves the store already committed.
- Reset has priority over every transition.

## Configuration
- `DMEM_BYTE_ACCESS_EN` defined: byte loads and stores behave as in Operation.
- Not defined:
  - `ByteAcc` is ignored and every access is a full word.
  - The byte-lane write enables collapse to all-ones.
  - The lane-select read mux is removed.

## Structure
- Shared package `dmem_pkg` holds:
  - the `dmem_state_t` enum (IDLE, WAIT, RESP);
  - the `DMEM_CNT_W`=4 constant;
  - a function mapping `{ByteAcc, Adr[1:0]}` to a 4-bit lane enable.
- One sub-module `dmem_array`: synchronous single-port RAM with 4 byte-write enables and registered read, instantiated once.

## Test plan
All scenarios use `WAIT_CYCLES`=2 and `DEPTH_WORDS`=64.

1. Reset, then store word `0xDEADBEEF` to `Adr`=`0x10`, then load `0x10` -> each `MemReady` arrives 3 cycles after `MemReq` rises; the load returns `0xDEADBEEF`; `MemBusy`=1 for 3 cycles per access.
2. Address wrap: store `0x12345678` at `0x100`, then load `0x0` -> `0x12345678`. Load `0x103` (word access) -> `0x12345678`.
3. Byte access, with `DMEM_BYTE_ACCESS_EN` defined:
   - word store `0x11223344` at `0x20`;
   - STRB `0xAA` to `0x21`;
   - word load of `0x20` -> `0x1122AA44`;
   - LDRB of `0x23` -> `0x00000011`.
4. Same sequence with `DMEM_BYTE_ACCESS_EN` undefined -> STRB writes the full word `0x000000AA`; LDRB of `0x23` returns `0x000000AA`.
5. Reset mid-operation: store `0xCAFEF00D` to `0x30`, assert `reset` in the first WAIT cycle -> no `MemReady`; all outputs 0 the next cycle; a later load of `0x30` returns the prior value `0x11111111`, written before the aborted store.
6. `MemReq` held high through RESP and dropped the next cycle -> exactly one `MemReady` pulse and one array write. `WAIT_CYCLES`=0 build: `MemReady` arrives 1 cycle after request.
